// File: rtl/regfile_writeback.sv
// Write-side master for the integer register file: merges ALU and load results onto one write port,
// buffers ALU-blocked loads in a small FIFO, and keeps a busy scoreboard. Optional macro: RFWB_FWD_EN.
module regfile_writeback #(
  parameter int unsigned W     = 32,
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         iss_valid,
  input  logic [4:0]   iss_rd,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  logic [W-1:0] alu_data,
  input  logic         mem_valid,
  output logic         mem_ready,
  input  logic [4:0]   mem_rd,
  input  logic [W-1:0] mem_data,
  output logic         wen,
  output logic [4:0]   wadd,
  output logic [W-1:0] wdata,
  output logic [N-1:0] busy
`ifdef RFWB_FWD_EN
  ,
  input  logic [4:0]   fwd_radd1,
  input  logic [4:0]   fwd_radd2,
  output logic         fwd1_hit,
  output logic         fwd2_hit
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [W-1:0]  r_fifo_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          r_wen;
  logic [4:0]    r_wadd;
  logic [W-1:0]  r_wdata;
  logic [N-1:0]  r_busy;

  logic          w_alu_v;
  logic          w_mem_v;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_wen_nxt;
  logic [4:0]    w_wadd_nxt;
  logic [W-1:0]  w_wdata_nxt;
  logic [N-1:0]  w_busy_nxt;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Results targeting r0 are accepted but treated as if no source were valid.
  assign mem_ready = (r_count < CW'(DEPTH));
  assign w_alu_v   = alu_valid & (alu_rd != 5'd0);
  assign w_mem_v   = mem_valid & mem_ready & (mem_rd != 5'd0);
  assign w_empty   = (r_count == '0);

  always_comb begin
    w_wen_nxt   = 1'b0;
    w_wadd_nxt  = r_wadd;
    w_wdata_nxt = r_wdata;
    w_pop       = 1'b0;
    if (w_alu_v) begin
      w_wen_nxt   = 1'b1;
      w_wadd_nxt  = alu_rd;
      w_wdata_nxt = alu_data;
    end else if (!w_empty) begin
      w_pop       = 1'b1;
      w_wen_nxt   = 1'b1;
      w_wadd_nxt  = r_fifo_rd[r_rd_ptr];
      w_wdata_nxt = r_fifo_data[r_rd_ptr];
    end else if (w_mem_v) begin
      w_wen_nxt   = 1'b1;
      w_wadd_nxt  = mem_rd;
      w_wdata_nxt = mem_data;
    end
    w_push = w_mem_v & (w_alu_v | !w_empty);
  end

  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wen) w_busy_nxt[r_wadd] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= mem_rd;
      r_fifo_data[r_wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wen    <= 1'b0;
      r_wadd   <= '0;
      r_wdata  <= '0;
      r_busy   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      r_wen   <= w_wen_nxt;
      r_wadd  <= w_wadd_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign wen   = r_wen;
  assign wadd  = r_wadd;
  assign wdata = r_wdata;
  assign busy  = r_busy;

`ifdef RFWB_FWD_EN
  assign fwd1_hit = r_wen & (r_wadd == fwd_radd1) & (r_wadd != 5'd0);
  assign fwd2_hit = r_wen & (r_wadd == fwd_radd2) & (r_wadd != 5'd0);
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU path, FIFO collision/full/drain, r0 drop, scoreboard race.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        nrst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wen;
  logic [4:0]  wadd;
  logic [31:0] wdata;
  logic [31:0] busy;
`ifdef RFWB_FWD_EN
  logic [4:0]  fwd_radd1;
  logic [4:0]  fwd_radd2;
  logic        fwd1_hit;
  logic        fwd2_hit;
`endif

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  regfile_writeback #(.W(32), .N(32), .DEPTH(2)) dut (
    .clk(clk), .nrst(nrst),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wen(wen), .wadd(wadd), .wdata(wdata), .busy(busy)
`ifdef RFWB_FWD_EN
    , .fwd_radd1(fwd_radd1), .fwd_radd2(fwd_radd2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic e_wen, input logic [4:0] e_add, input logic [31:0] e_dat);
    check({tag, ".wen"}, {31'd0, wen}, {31'd0, e_wen});
    if (e_wen) begin
      check({tag, ".wadd"}, {27'd0, wadd}, {27'd0, e_add});
      check({tag, ".wdata"}, wdata, e_dat);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  initial begin
    nrst = 1'b0;
    idle();
`ifdef RFWB_FWD_EN
    fwd_radd1 = '0; fwd_radd2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst.wen", {31'd0, wen}, 32'd0);
    check("rst.wadd", {27'd0, wadd}, 32'd0);
    check("rst.wdata", wdata, 32'd0);
    check("rst.busy", busy, 32'd0);
    check("rst.ready", {31'd0, mem_ready}, 32'd1);
    nrst = 1'b1;

    // ALU only, with r5 issued first
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    check("iss.busy", busy, 32'h0000_0020);
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    chk_wr("alu", 1'b1, 5'd5, 32'h1234);
    check("alu.busy_pending", busy, 32'h0000_0020);
    idle();
    tick();
    check("alu.busy_cleared", busy, 32'd0);
    check("alu.idle_wen", {31'd0, wen}, 32'd0);
    check("alu.hold_wadd", {27'd0, wadd}, 32'd5);
    check("alu.hold_wdata", wdata, 32'h1234);

    // Collision: ALU wins, load is popped next cycle
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
    tick();
    chk_wr("col1", 1'b1, 5'd3, 32'hA);
    idle();
    tick();
    chk_wr("col2", 1'b1, 5'd4, 32'hB);
    tick();
    chk_wr("col3", 1'b0, 5'd0, 32'd0);

    // Full: three ALU cycles with a load stream
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h200;
    tick();
    chk_wr("full1", 1'b1, 5'd10, 32'h100);
    check("full1.ready", {31'd0, mem_ready}, 32'd1);
    alu_rd = 5'd11; alu_data = 32'h110;
    mem_rd = 5'd21; mem_data = 32'h210;
    tick();
    chk_wr("full2", 1'b1, 5'd11, 32'h110);
    check("full2.ready", {31'd0, mem_ready}, 32'd0);
    alu_rd = 5'd12; alu_data = 32'h120;
    mem_rd = 5'd22; mem_data = 32'h220;
    tick();
    chk_wr("full3", 1'b1, 5'd12, 32'h120);
    check("full3.ready", {31'd0, mem_ready}, 32'd0);
    alu_valid = 1'b0;
    tick();
    chk_wr("drain1", 1'b1, 5'd20, 32'h200);
    check("drain1.ready", {31'd0, mem_ready}, 32'd1);
    tick();
    chk_wr("drain2", 1'b1, 5'd21, 32'h210);
    idle();
    tick();
    chk_wr("drain3", 1'b1, 5'd22, 32'h220);
    tick();
    chk_wr("drain4", 1'b0, 5'd0, 32'd0);
    check("drain4.ready", {31'd0, mem_ready}, 32'd1);

    // rd==0 ALU does not block a bypassed load
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
    tick();
    chk_wr("r0.bypass", 1'b1, 5'd7, 32'h77);
    idle();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBEEF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    chk_wr("r0.drop", 1'b0, 5'd0, 32'd0);
    check("r0.busy", busy, 32'd0);
    check("r0.ready", {31'd0, mem_ready}, 32'd1);
    idle();
    tick();
    chk_wr("r0.no_pop", 1'b0, 5'd0, 32'd0);

    // Scoreboard race: set wins over clear on the same register
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    tick();
    chk_wr("race.wr", 1'b1, 5'd9, 32'h99);
    idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
`ifdef RFWB_FWD_EN
    fwd_radd1 = 5'd9; fwd_radd2 = 5'd8;
    #1;
    check("fwd1.hit", {31'd0, fwd1_hit}, 32'd1);
    check("fwd2.miss", {31'd0, fwd2_hit}, 32'd0);
`endif
    tick();
    check("race.busy", busy, 32'h0000_0200);
    idle();

    // Mid-stream async reset with FIFO occupied and busy bits pending
    iss_valid = 1'b1; iss_rd = 5'd6;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h22;
    tick();
    chk_wr("mid.pre", 1'b1, 5'd1, 32'h11);
    check("mid.pre_busy", busy, 32'h0000_0240);
    idle();
    #2;
    nrst = 1'b0;
    #1;
    check("mid.wen", {31'd0, wen}, 32'd0);
    check("mid.busy", busy, 32'd0);
    check("mid.ready", {31'd0, mem_ready}, 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    tick();
    chk_wr("mid.fifo_empty", 1'b0, 5'd0, 32'd0);
    tick();
    chk_wr("mid.fifo_empty2", 1'b0, 5'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
